// File: rtl/stage_wb_queued.sv
// Writeback stage: formats load data and registers RF/HI-LO writes, merging long-latency
// (divider) results through a small FIFO that only uses a port when the pipeline leaves it free.
module stage_wb_queued #(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_i_valid,
    input  logic                         wb_i_rfwe,
    input  logic                         wb_i_hilowe,
    input  logic                         wb_i_dm2rf,
    input  logic [4:0]                   wb_i_rfwa,
    input  logic [DW-1:0]                wb_i_alures,
    input  logic [DW-1:0]                wb_i_dmdout,
    input  logic [2*DW-1:0]              wb_i_mulres,
    input  logic [1:0]                   wb_i_ldsize,
    input  logic                         wb_i_ldsign,
    input  logic [1:0]                   wb_i_addrlo,
    input  logic                         ll_valid,
    output logic                         ll_ready,
    input  logic                         ll_tohilo,
    input  logic [4:0]                   ll_rfwa,
    input  logic [2*DW-1:0]              ll_res,
    output logic                         rfwe,
    output logic [4:0]                   rfwa,
    output logic [DW-1:0]                rfwd,
    output logic                         hilowe,
    output logic [DW-1:0]                hi_i,
    output logic [DW-1:0]                lo_i,
    output logic                         wb_stall,
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic            r_qHilo [DEPTH];
    logic [4:0]      r_qRfwa [DEPTH];
    logic [2*DW-1:0] r_qRes  [DEPTH];
    logic [PW-1:0]   r_rdPtr;
    logic [PW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_cnt;

    logic [DW-1:0]   w_byteSh;
    logic [DW-1:0]   w_halfSh;
    logic [DW-1:0]   w_ldData;
    logic [DW-1:0]   w_pipeRfwd;
    logic            w_pipeRf;
    logic            w_pipeHl;
    logic            w_nonEmpty;
    logic            w_full;
    logic            w_headHilo;
    logic            w_headBlocked;
    logic            w_drain;
    logic            w_push;
    logic            w_drainRf;
    logic            w_drainHl;

    // Half loads pick the upper or lower halfword; the low address bit is ignored.
    assign w_byteSh = wb_i_dmdout >> {wb_i_addrlo, 3'b000};
    assign w_halfSh = wb_i_dmdout >> {wb_i_addrlo[1], 4'b0000};

    always_comb begin
        w_ldData = wb_i_dmdout;
        case (wb_i_ldsize)
            2'b00:   w_ldData = {{(DW-8){wb_i_ldsign & w_byteSh[7]}}, w_byteSh[7:0]};
            2'b01:   w_ldData = {{(DW-16){wb_i_ldsign & w_halfSh[15]}}, w_halfSh[15:0]};
            default: w_ldData = wb_i_dmdout;
        endcase
    end

    assign w_pipeRfwd = wb_i_dm2rf ? w_ldData : wb_i_alures;
    assign w_pipeRf   = wb_i_valid & wb_i_rfwe;
    assign w_pipeHl   = wb_i_valid & wb_i_hilowe;

    // The head only waits when the pipeline claims the same port this cycle.
    assign w_nonEmpty    = (r_cnt != '0);
    assign w_full        = (r_cnt == CW'(DEPTH));
    assign w_headHilo    = r_qHilo[r_rdPtr];
    assign w_headBlocked = w_nonEmpty & (w_headHilo ? w_pipeHl : w_pipeRf);
    assign w_drain       = w_nonEmpty & ~w_headBlocked;
    assign w_drainRf     = w_drain & ~w_headHilo;
    assign w_drainHl     = w_drain & w_headHilo;

    assign ll_ready = ~rst & ~w_full;
    assign w_push   = ll_valid & ll_ready;
    assign wb_stall = ~rst & w_full & w_headBlocked;
    assign pend_cnt = r_cnt;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qHilo[r_wrPtr] <= ll_tohilo;
            r_qRfwa[r_wrPtr] <= ll_rfwa;
            r_qRes[r_wrPtr]  <= ll_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_push)  r_wrPtr <= incPtr(r_wrPtr);
            if (w_drain) r_rdPtr <= incPtr(r_rdPtr);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_drain);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rfwe   <= 1'b0;
            rfwa   <= '0;
            rfwd   <= '0;
            hilowe <= 1'b0;
            hi_i   <= '0;
            lo_i   <= '0;
        end else begin
            rfwe   <= w_pipeRf | w_drainRf;
            hilowe <= w_pipeHl | w_drainHl;
            if (w_pipeRf) begin
                rfwa <= wb_i_rfwa;
                rfwd <= w_pipeRfwd;
            end else if (w_drainRf) begin
                rfwa <= r_qRfwa[r_rdPtr];
                rfwd <= r_qRes[r_rdPtr][DW-1:0];
            end
            if (w_pipeHl) begin
                hi_i <= wb_i_mulres[2*DW-1:DW];
                lo_i <= wb_i_mulres[DW-1:0];
            end else if (w_drainHl) begin
                hi_i <= r_qRes[r_rdPtr][2*DW-1:DW];
                lo_i <= r_qRes[r_rdPtr][DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_stage_wb_queued.sv
// Bench for stage_wb_queued: load-format vector table, directed queue sequences,
// then randomized traffic against a queue-based reference model.
module tb_stage_wb_queued;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_i_valid, wb_i_rfwe, wb_i_hilowe, wb_i_dm2rf;
    logic [4:0]  wb_i_rfwa;
    logic [31:0] wb_i_alures, wb_i_dmdout;
    logic [63:0] wb_i_mulres;
    logic [1:0]  wb_i_ldsize;
    logic        wb_i_ldsign;
    logic [1:0]  wb_i_addrlo;
    logic        ll_valid, ll_ready, ll_tohilo;
    logic [4:0]  ll_rfwa;
    logic [63:0] ll_res;
    logic        rfwe, hilowe, wb_stall;
    logic [4:0]  rfwa;
    logic [31:0] rfwd, hi_i, lo_i;
    logic [1:0]  pend_cnt;

    always #5 clk = ~clk;

    stage_wb_queued #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wb_i_valid(wb_i_valid), .wb_i_rfwe(wb_i_rfwe), .wb_i_hilowe(wb_i_hilowe),
        .wb_i_dm2rf(wb_i_dm2rf), .wb_i_rfwa(wb_i_rfwa), .wb_i_alures(wb_i_alures),
        .wb_i_dmdout(wb_i_dmdout), .wb_i_mulres(wb_i_mulres), .wb_i_ldsize(wb_i_ldsize),
        .wb_i_ldsign(wb_i_ldsign), .wb_i_addrlo(wb_i_addrlo),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_tohilo(ll_tohilo),
        .ll_rfwa(ll_rfwa), .ll_res(ll_res),
        .rfwe(rfwe), .rfwa(rfwa), .rfwd(rfwd), .hilowe(hilowe), .hi_i(hi_i), .lo_i(lo_i),
        .wb_stall(wb_stall), .pend_cnt(pend_cnt)
    );

    typedef struct {
        bit        tohilo;
        bit [4:0]  rfwa;
        bit [63:0] res;
    } llEntry_t;

    typedef struct {
        bit [1:0]  ldsize;
        bit        ldsign;
        bit [1:0]  addrlo;
        bit [31:0] dmdout;
        bit [31:0] expRfwd;
    } loadVec_t;

    llEntry_t  mq[$];
    loadVec_t  vecs[10];
    int        checks = 0;
    int        errors = 0;
    bit        eRfwe, eHilowe, eAll;
    bit [4:0]  eRfwa;
    bit [31:0] eRfwd, eHi, eLo;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit we, input bit hlwe, input bit dm2rf,
                                 input bit [4:0] wa, input bit [31:0] alu, input bit [31:0] dm,
                                 input bit [63:0] mul, input bit [1:0] sz, input bit sgn,
                                 input bit [1:0] alo);
        wb_i_valid  = v;   wb_i_rfwe   = we;  wb_i_hilowe = hlwe; wb_i_dm2rf = dm2rf;
        wb_i_rfwa   = wa;  wb_i_alures = alu; wb_i_dmdout = dm;   wb_i_mulres = mul;
        wb_i_ldsize = sz;  wb_i_ldsign = sgn; wb_i_addrlo = alo;
    endtask

    task automatic applyLl(input bit v, input bit toHl, input bit [4:0] wa, input bit [63:0] res);
        ll_valid = v; ll_tohilo = toHl; ll_rfwa = wa; ll_res = res;
    endtask

    task automatic pipeIdle();
        applyStimulus(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 64'h0, 2'd2, 1'b0, 2'd0);
    endtask

    task automatic pipeRf(input bit [4:0] wa, input bit [31:0] alu);
        applyStimulus(1, 1, 0, 0, wa, alu, 32'h0, 64'h0, 2'd2, 1'b0, 2'd0);
    endtask

    function automatic bit [31:0] fmtLoad(input bit [1:0] sz, input bit sgn, input bit [1:0] alo,
                                          input bit [31:0] word);
        bit [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> (8 * alo)) & 32'hFF;
            if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (word >> (16 * (alo / 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    // One clock: check the handshake outputs against the model, advance the model, check registered outputs.
    task automatic stepCycle();
        bit       blocked, expReady, expStall;
        llEntry_t h, e;
        #1;
        blocked = 1'b0;
        if (mq.size() > 0)
            blocked = mq[0].tohilo ? (wb_i_valid && wb_i_hilowe) : (wb_i_valid && wb_i_rfwe);
        expReady = !rst && (mq.size() < DEPTH);
        expStall = !rst && (mq.size() == DEPTH) && blocked;
        checkOutput("ll_ready", ll_ready, expReady);
        checkOutput("wb_stall", wb_stall, expStall);
        eRfwe = 0; eHilowe = 0; eAll = 0;
        if (rst) begin
            mq.delete();
            eRfwa = 0; eRfwd = 0; eHi = 0; eLo = 0; eAll = 1;
        end else begin
            if (wb_i_valid && wb_i_rfwe) begin
                eRfwe = 1; eRfwa = wb_i_rfwa;
                eRfwd = wb_i_dm2rf ? fmtLoad(wb_i_ldsize, wb_i_ldsign, wb_i_addrlo, wb_i_dmdout)
                                   : wb_i_alures;
            end
            if (wb_i_valid && wb_i_hilowe) begin
                eHilowe = 1; eHi = wb_i_mulres[63:32]; eLo = wb_i_mulres[31:0];
            end
            if (mq.size() > 0 && !blocked) begin
                h = mq.pop_front();
                if (h.tohilo) begin
                    eHilowe = 1; eHi = h.res[63:32]; eLo = h.res[31:0];
                end else begin
                    eRfwe = 1; eRfwa = h.rfwa; eRfwd = h.res[31:0];
                end
            end
            if (ll_valid && expReady) begin
                e.tohilo = ll_tohilo; e.rfwa = ll_rfwa; e.res = ll_res;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("rfwe", rfwe, eRfwe);
        checkOutput("hilowe", hilowe, eHilowe);
        checkOutput("pend_cnt", pend_cnt, mq.size());
        if (eRfwe || eAll) begin
            checkOutput("rfwa", rfwa, eRfwa);
            checkOutput("rfwd", rfwd, eRfwd);
        end
        if (eHilowe || eAll) begin
            checkOutput("hi_i", hi_i, eHi);
            checkOutput("lo_i", lo_i, eLo);
        end
    endtask

    initial begin
        vecs[0] = '{2'd0, 1'b1, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
        vecs[1] = '{2'd0, 1'b0, 2'd3, 32'h80FF_1234, 32'h0000_0080};
        vecs[2] = '{2'd1, 1'b1, 2'd2, 32'h8001_7FFF, 32'hFFFF_8001};
        vecs[3] = '{2'd1, 1'b1, 2'd0, 32'h8001_7FFF, 32'h0000_7FFF};
        vecs[4] = '{2'd0, 1'b1, 2'd0, 32'h80FF_1234, 32'h0000_0034};
        vecs[5] = '{2'd0, 1'b1, 2'd2, 32'h80FF_1234, 32'hFFFF_FFFF};
        vecs[6] = '{2'd1, 1'b0, 2'd3, 32'h8001_7FFF, 32'h0000_8001};
        vecs[7] = '{2'd2, 1'b1, 2'd1, 32'h80FF_1234, 32'h80FF_1234};
        vecs[8] = '{2'd3, 1'b1, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[9] = '{2'd0, 1'b0, 2'd1, 32'h80FF_1234, 32'h0000_0012};

        rst = 1'b1;
        pipeIdle();
        applyLl(0, 0, 5'd0, 64'h0);
        stepCycle();
        stepCycle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, 1, 5'd5, 32'h0, vecs[i].dmdout, 64'h0,
                          vecs[i].ldsize, vecs[i].ldsign, vecs[i].addrlo);
            stepCycle();
            checkOutput($sformatf("load_vec%0d_rfwd", i), rfwd, vecs[i].expRfwd);
            checkOutput($sformatf("load_vec%0d_rfwa", i), rfwa, 5'd5);
        end
        pipeIdle();
        stepCycle();

        // Long-latency HI/LO result with an idle pipeline: two cycles accept-to-output.
        applyLl(1, 1, 5'd0, 64'h0000_0003_0000_0007);
        stepCycle();
        checkOutput("llhl_pend_n1", pend_cnt, 1);
        applyLl(0, 0, 5'd0, 64'h0);
        stepCycle();
        checkOutput("llhl_hilowe_n2", hilowe, 1);
        checkOutput("llhl_hi_n2", hi_i, 32'h3);
        checkOutput("llhl_lo_n2", lo_i, 32'h7);
        checkOutput("llhl_pend_n2", pend_cnt, 0);

        // Queue fills behind a busy pipeline, one bubble drains the head, order preserved.
        pipeRf(5'd1, 32'h100);
        applyLl(1, 0, 5'd10, 64'hA);
        stepCycle();
        pipeRf(5'd2, 32'h200);
        applyLl(1, 0, 5'd11, 64'hB);
        stepCycle();
        pipeRf(5'd3, 32'h300);
        applyLl(1, 0, 5'd12, 64'hC);
        #1;
        checkOutput("full_ll_ready", ll_ready, 0);
        checkOutput("full_wb_stall", wb_stall, 1);
        stepCycle();
        pipeIdle();
        stepCycle();
        checkOutput("bubble_rfwe", rfwe, 1);
        checkOutput("bubble_rfwa_first", rfwa, 5'd10);
        checkOutput("bubble_rfwd_first", rfwd, 32'hA);
        pipeRf(5'd4, 32'h400);
        stepCycle();
        applyLl(0, 0, 5'd0, 64'h0);
        pipeIdle();
        stepCycle();
        checkOutput("order_rfwa_second", rfwa, 5'd11);
        stepCycle();
        checkOutput("order_rfwa_third", rfwa, 5'd12);
        stepCycle();

        // Pipeline RF write and queued HI/LO head leave in the same output cycle.
        pipeRf(5'd3, 32'h1111);
        applyLl(1, 1, 5'd0, 64'hAAAA_BBBB_CCCC_DDDD);
        stepCycle();
        pipeRf(5'd4, 32'h2222);
        applyLl(0, 0, 5'd0, 64'h0);
        stepCycle();
        checkOutput("dual_rfwe", rfwe, 1);
        checkOutput("dual_hilowe", hilowe, 1);
        checkOutput("dual_rfwa", rfwa, 5'd4);
        checkOutput("dual_hi", hi_i, 32'hAAAA_BBBB);
        checkOutput("dual_lo", lo_i, 32'hCCCC_DDDD);

        // Reset with two queued entries discards them silently.
        pipeRf(5'd6, 32'h6);
        applyLl(1, 0, 5'd20, 64'h20);
        stepCycle();
        pipeRf(5'd7, 32'h7);
        applyLl(1, 0, 5'd21, 64'h21);
        stepCycle();
        checkOutput("prerst_pend", pend_cnt, 2);
        pipeIdle();
        applyLl(0, 0, 5'd0, 64'h0);
        rst = 1'b1;
        stepCycle();
        checkOutput("rst_pend", pend_cnt, 0);
        checkOutput("rst_rfwe", rfwe, 0);
        checkOutput("rst_hilowe", hilowe, 0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("postrst_ll_ready", ll_ready, 1);
        for (int i = 0; i < 3; i++) stepCycle();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1), 5'($urandom), $urandom, $urandom,
                          {$urandom, $urandom}, 2'($urandom), 1'($urandom), 2'($urandom));
            applyLl($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom), {$urandom, $urandom});
            stepCycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_wb_queued.md
STAGE_WB_QUEUED -- requirements
Module: stage_wb_queued

Interface
REQ-001 Parameter DW, default 32: register data width; HI/LO and long-latency results are 2*DW.
REQ-002 Parameter DEPTH, default 2: long-latency pending-queue entries; legal range 1..8.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 wb_i_valid  in  1  pipeline writeback slot carries an instruction.
REQ-006 wb_i_rfwe / wb_i_hilowe / wb_i_dm2rf  in  1 each  RF write, HI/LO write, select load data for rfwd.
REQ-007 wb_i_rfwa  in  5  RF destination.
REQ-008 wb_i_alures / wb_i_dmdout  in  DW each  ALU result, raw data-memory word.
REQ-009 wb_i_mulres  in  2*DW  multiply result {hi,lo}.
REQ-010 wb_i_ldsize  in  2  00 byte, 01 half, 10/11 word; wb_i_ldsign in 1 (1 = sign-extend); wb_i_addrlo in 2 (byte offset).
REQ-011 ll_valid / ll_ready  in / out  1 each  long-latency (divider) result handshake.
REQ-012 ll_tohilo  in  1  1 = result targets HI/LO, 0 = RF using ll_res[DW-1:0].
REQ-013 ll_rfwa  in  5; ll_res  in  2*DW  long-latency destination and result.
REQ-014 rfwe / rfwa / rfwd  out  1 / 5 / DW  registered RF write port.
REQ-015 hilowe / hi_i / lo_i  out  1 / DW / DW  registered HI/LO write port.
REQ-016 wb_stall  out  1  upstream must hold the writeback slot.
REQ-017 pend_cnt  out  clog2(DEPTH+1)  current queue occupancy.

Function
REQ-018 Load formatting: shifted = wb_i_dmdout >> (8*wb_i_addrlo); byte uses shifted[7:0], half uses (wb_i_dmdout >> 16*wb_i_addrlo[1])[15:0] (addrlo[0] ignored), word uses wb_i_dmdout unshifted.
REQ-019 Byte/half extension: ldsign=1 replicates MSB of the field into upper bits, ldsign=0 zero-fills.
REQ-020 Pipeline data: rfwd source = formatted load if wb_i_dm2rf else wb_i_alures; hi/lo source = wb_i_mulres[2DW-1:DW] / [DW-1:0].
REQ-021 Pipeline writes (wb_i_valid=1) appear on output ports exactly 1 cycle later; wb_i_valid=0 suppresses rfwe and hilowe.
REQ-022 Queue: FIFO of DEPTH entries {tohilo, rfwa, res}; push when ll_valid && ll_ready; ll_ready = (pend_cnt < DEPTH), from registered state only.
REQ-023 Port priority: pipeline always wins; queue head drains to its target port in a cycle where the pipeline is not writing that same port (RF head blocked only by wb_i_valid&&wb_i_rfwe; HI/LO head only by wb_i_valid&&wb_i_hilowe).
REQ-024 At most one queue entry drains per cycle; drained entry appears on outputs 1 cycle after the drain cycle (minimum ll accept-to-output latency 2 cycles; no bypass).
REQ-025 A pipeline write to one port and a queue drain to the other port shall both appear in the same output cycle.
REQ-026 Simultaneous push and drain: occupancy unchanged; allowed at full only if drain is computed before push (ll_ready still 0 at full; no same-cycle refill).
REQ-027 wb_stall = 1 whenever pend_cnt == DEPTH and head is blocked by the current pipeline slot; otherwise 0.
REQ-028 FIFO order preserved; wrap-around of read/write pointers at DEPTH for any DEPTH (no power-of-two requirement).
REQ-029 WAW ordering between queue and pipeline is guaranteed by issue logic; this block does not check it.

Reset
REQ-030 While rst=1: rfwe=0, hilowe=0, rfwa=0, rfwd=0, hi_i=0, lo_i=0, pend_cnt=0, queue emptied, ll_ready=0, wb_stall=0.
REQ-031 First cycle after rst falls: ll_ready=1; reset asserted mid-drain discards all queued entries without writing them.

Verification
REQ-032 lb, dmdout=0x80FF_1234, addrlo=3, ldsign=1, rfwa=5 -> next cycle rfwe=1, rfwa=5, rfwd=0xFFFF_FF80; ldsign=0 -> 0x0000_0080.
REQ-033 lh, dmdout=0x8001_7FFF, addrlo=2, ldsign=1 -> rfwd=0xFFFF_8001; addrlo=0 -> 0x0000_7FFF.
REQ-034 Idle pipeline, ll push tohilo=1, res=0x0000_0003_0000_0007 at cycle N -> cycle N+2 hilowe=1, hi_i=3, lo_i=7; pend_cnt 1 at N+1, 0 at N+2.
REQ-035 DEPTH=2, pipeline writing RF every cycle, three RF ll pushes -> ll_ready=0 after two, wb_stall=1; one bubble drains head, entries exit in push order.
REQ-036 Pipeline RF write and queued HI/LO head same cycle -> rfwe=1 and hilowe=1 together next cycle.
REQ-037 rst asserted with pend_cnt=2 -> next cycle pend_cnt=0, no rfwe/hilowe pulses from discarded entries.
